// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared types and defaults for the multi-read-port register bank
package register_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 32;
  localparam int NREAD_DEF  = 2;
  localparam int NREAD_MAX  = 4;

endpackage

// File: rtl/register_bank_scoreboard.sv
// rtl/register_bank_scoreboard.sv - per-register busy bits for pending writebacks
module register_bank_scoreboard
  import register_bank_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NREAD  = NREAD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wen,
  input  logic [AWIDTH-1:0]       waddr,
  input  logic                    rsv_en,
  input  logic [AWIDTH-1:0]       rsv_addr,
  input  logic [NREAD*AWIDTH-1:0] raddr,
  output logic [NREAD-1:0]        rbusy
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [AWIDTH-1:0] ra;

  // Writeback clears, reserve sets; reserve is applied last so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (en) begin
      if (wen && (waddr != '0)) begin
        busy_d[waddr] = 1'b0;
      end
      if (rsv_en && (rsv_addr != '0)) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register; reset drops every pending writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy lookup; location 0 and a not-yet-ready bank always read idle.
  always_comb begin
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra       = raddr[i*AWIDTH +: AWIDTH];
      rbusy[i] = en && (ra != '0) && busy_q[ra];
    end
  end

endmodule

// File: rtl/register_bank_mp.sv
// rtl/register_bank_mp.sv - multi-read-port register bank with clear sequencer; optional BYPASS_EN write-to-read bypass
module register_bank_mp
  import register_bank_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NREAD  = NREAD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AWIDTH-1:0] raddr,
  output logic [NREAD*DWIDTH-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    wen,
  input  logic [AWIDTH-1:0]       waddr,
  input  logic [DWIDTH-1:0]       wdata,
  input  logic                    rsv_en,
  input  logic [AWIDTH-1:0]       rsv_addr,
  output logic                    ready,
  output logic                    err
);

  localparam int DEPTH = 1 << AWIDTH;

  if ((NREAD < 1) || (NREAD > NREAD_MAX)) begin : g_nread_check
    $error("register_bank_mp: NREAD must be in 1..4");
  end

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [NREAD-1:0]  sb_rbusy;
  logic [AWIDTH-1:0] ra;
  logic              hit;

  assign ready = (state_q == RUN);
  assign err   = err_q;

  // Clear sequencer and the single array write port it shares with writeback.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = wdata;
    if (rst) begin
      state_d    = CLEAR;
      clr_addr_d = AWIDTH'(1);
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we     = 1'b1;
          mem_waddr  = clr_addr_q;
          mem_wdata  = '0;
          clr_addr_d = clr_addr_q + AWIDTH'(1);
          err_d      = wen | rsv_en;
          if (clr_addr_q == {AWIDTH{1'b1}}) begin
            state_d = RUN;
          end
        end
        RUN: begin
          mem_we = wen && (waddr != '0);
        end
        default: begin
          state_d = CLEAR;
        end
      endcase
    end
  end

  // Control registers; reset restarts the clear from location 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= AWIDTH'(1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_q      <= err_d;
    end
  end

  // Storage array; location 0 is never written and is masked on read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  register_bank_scoreboard #(
    .AWIDTH (AWIDTH),
    .NREAD  (NREAD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (ready),
    .wen      (wen),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .raddr    (raddr),
    .rbusy    (sb_rbusy)
  );

  // Read ports: zero while clearing or for location 0, optionally forwarding a same-cycle write.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit   = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra  = raddr[i*AWIDTH +: AWIDTH];
`ifdef BYPASS_EN
      hit = wen && (waddr == ra);
`else
      hit = 1'b0;
`endif
      if (ready && (ra != '0)) begin
        if (hit) begin
          rdata[i*DWIDTH +: DWIDTH] = wdata;
          rbusy[i]                  = rsv_en && (rsv_addr == ra);
        end else begin
          rdata[i*DWIDTH +: DWIDTH] = mem_q[ra];
          rbusy[i]                  = sb_rbusy[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// tb/tb_register_bank_mp.sv - self-checking bench for register_bank_mp against a behavioural model
module tb_register_bank_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             ready;
  logic             err;

  always #5 clk = ~clk;

  register_bank_mp #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .NREAD  (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: contents, busy flags, and a count of clear cycles since reset.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready;
  bit            m_err;
  bit            m_valid = 1'b0;
  int            m_clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ra(input int i, input logic [AW-1:0] a);
    raddr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd0();
    return rdata[DW-1:0];
  endfunction

  task automatic model_check();
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    bit            eb;
    if (!m_valid) return;
    check("ready", ready, m_ready);
    check("err", err, m_err);
    for (int i = 0; i < NR; i++) begin
      a  = raddr[i*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_ready && a != 0) begin
        if (BYP && wen && waddr == a) begin
          ed = wdata;
          eb = rsv_en && (rsv_addr == a);
        end else begin
          ed = m_mem[a];
          eb = m_busy[a];
        end
      end
      check($sformatf("rdata%0d@%0d", i, a), rdata[i*DW +: DW], ed);
      check($sformatf("rbusy%0d@%0d", i, a), rbusy[i], eb);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_clr   = 0;
      foreach (m_busy[k]) m_busy[k] = 1'b0;
    end else if (m_valid) begin
      m_err = !m_ready && (wen || rsv_en);
      if (!m_ready) begin
        m_clr++;
        if (m_clr == DEPTH - 1) begin
          m_ready = 1'b1;
          foreach (m_mem[k]) m_mem[k] = '0;
        end
      end else begin
        if (wen && waddr != 0) begin
          m_mem[waddr]  = wdata;
          m_busy[waddr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic sample();
    #3;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst    = 1'b0;
    wen    = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; rsv_en = 1'b0;
    waddr = '0; wdata = '0; rsv_addr = '0; raddr = '0;
    advance();

    // Power-up clear: ready rises at cycle 31, reads stay zero.
    idle();
    set_ra(0, 5'd7);
    for (int k = 0; k <= 31; k++) begin
      sample();
      if (k == 0) begin
        check("reset_err", err, 1'b0);
        check("reset_rbusy", rbusy, '0);
      end
      check($sformatf("clr_ready_c%0d", k), ready, (k == 31));
      check("clr_rdata0", rd0(), 32'h0);
      advance();
    end

    // Preload 7, then reset clears it.
    wen = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    sample(); advance();
    idle();
    sample(); check("preload7", rd0(), 32'hDEADBEEF); advance();
    rst = 1'b1;
    sample(); advance();
    idle();
    for (int k = 0; k <= 31; k++) begin
      sample();
      check($sformatf("rst_ready_c%0d", k), ready, (k == 31));
      check("rst_rdata0", rd0(), 32'h0);
      advance();
    end

    // Request during clear, then reset mid-clear.
    rst = 1'b1; sample(); advance(); idle();
    for (int k = 0; k < 10; k++) begin
      wen = (k == 4); waddr = 5'd9; wdata = 32'h99;
      sample();
      if (k == 5) check("nr_err_hi", err, 1'b1);
      if (k == 6) check("nr_err_lo", err, 1'b0);
      advance();
    end
    idle();
    rst = 1'b1; sample(); advance(); idle();
    for (int k = 0; k <= 31; k++) begin
      sample();
      check($sformatf("mid_ready_c%0d", k), ready, (k == 31));
      advance();
    end
    set_ra(0, 5'd9);
    sample(); check("nr_loc9", rd0(), 32'h0); advance();

    // Write/read on two ports, write to 0 discarded.
    wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    set_ra(0, 5'd5); set_ra(1, 5'd5);
    sample(); check("wr5_same", rd0(), BYP ? 32'h12345678 : 32'h0); advance();
    idle();
    sample();
    check("wr5_p0", rd0(), 32'h12345678);
    check("wr5_p1", rdata[2*DW-1:DW], 32'h12345678);
    advance();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_ra(0, 5'd0);
    sample(); advance(); idle();
    sample(); check("loc0", rd0(), 32'h0); advance();

    // Scoreboard: reserve, writeback, and collision.
    set_ra(0, 5'd3);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    sample(); advance(); idle();
    sample(); check("rsv3_busy", rbusy[0], 1'b1); advance();
    wen = 1'b1; waddr = 5'd3; wdata = 32'h33;
    sample(); advance(); idle();
    sample(); check("wb3_idle", rbusy[0], 1'b0); advance();
    wen = 1'b1; waddr = 5'd3; wdata = 32'h44; rsv_en = 1'b1; rsv_addr = 5'd3;
    sample(); advance(); idle();
    sample();
    check("col3_busy", rbusy[0], 1'b1);
    check("col3_data", rd0(), 32'h44);
    advance();

    // Same-cycle write visibility.
    set_ra(0, 5'd2);
    wen = 1'b1; waddr = 5'd2; wdata = 32'hA5;
    sample(); check("byp2_same", rd0(), BYP ? 32'hA5 : 32'h0); advance();
    idle();
    sample(); check("byp2_next", rd0(), 32'hA5); advance();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NR; i++) set_ra(i, AW'($urandom_range(0, DEPTH - 1)));
      wen      = $urandom_range(0, 1) == 1;
      waddr    = ($urandom_range(0, 2) == 0) ? raddr[AW-1:0] : AW'($urandom_range(0, DEPTH - 1));
      wdata    = $urandom;
      rsv_en   = $urandom_range(0, 2) == 0;
      rsv_addr = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
# register_bank_mp

Parametrised multi-read-port register bank for the simplified RISC-V core. It replaces the fixed 2-read/1-write bank, keeps location 0 hardwired to zero, and adds three things:
- a hardware clear sequencer that zeroes every location after reset;
- a per-register busy scoreboard for pending writebacks;
- optional same-cycle write-to-read bypass.

It sits between decode (read/reserve) and writeback (write).

## Interface
- AWIDTH, 5, address width; bank holds 2**AWIDTH locations, location 0 read-only zero
- DWIDTH, 32, data width
- NREAD, 2, number of independent read ports (1..4)
- clk  in  1  clock; everything is on its rising edge
- rst  in  1  reset, synchronous, active-high
- raddr  in  NREAD*AWIDTH  read addresses, port i at bits [i*AWIDTH +: AWIDTH]
- rdata  out  NREAD*DWIDTH  read data, port i at bits [i*DWIDTH +: DWIDTH], combinational from raddr
- rbusy  out  NREAD  busy bit of the location addressed by port i
- wen  in  1  write enable
- waddr  in  AWIDTH  write address
- wdata  in  DWIDTH  write data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  AWIDTH  location to reserve
- ready  out  1  bank initialised; writes and reserves are accepted
- err  out  1  registered one-cycle pulse; reports a write or reserve issued while ready=0

## Operation
- **States:** CLEAR and RUN. A clear counter clr_addr of AWIDTH bits walks the bank.
- **Reset:** any cycle with rst=1 produces the following, regardless of current state (a reset mid-clear restarts the clear from location 1):
  - state <= CLEAR, clr_addr <= 1
  - all busy bits <= 0
  - ready <= 0, err <= 0
  - no array write takes place
- **CLEAR:** each cycle with rst=0 writes 0 to clr_addr and increments it. When clr_addr == 2**AWIDTH-1, that location is written and the state moves to RUN.
- **While ready=0:**
  - wen and rsv_en are ignored.
  - err <= wen | rsv_en.
  - rdata reads all-zero on every port.
  - rbusy reads 0 on every port.
- **RUN, write:** wen=1 and waddr!=0 stores wdata and clears busy[waddr]. A write to 0 is discarded.
- **RUN, reserve:** rsv_en=1 and rsv_addr!=0 sets busy[rsv_addr]. Reserving 0 is a no-op. Reserving an already-busy location keeps it busy.
- **Reserve and write to the same address in one cycle:** reserve wins, so busy ends at 1. The data is still written.
- **Reads:**
  - raddr=0 gives rdata=0 and rbusy=0, always.
  - Otherwise rdata is the stored word and rbusy is the busy bit.
  - Any number of ports may read the same address.
- **Location 0:** never written and never busy. Storage for location 0 may be omitted.

## Timing
- Read path is combinational, with zero latency from raddr to rdata and rbusy.
- A write becomes visible on rdata the cycle after wen; with BYPASS_EN it is visible the same cycle.
- busy set/clear takes effect one cycle after rsv_en or wen.
- ready=1 exactly 2**AWIDTH-1 cycles after the first cycle with rst=0. For AWIDTH=5, cycles 0..30 clear locations 1..31 and ready=1 from cycle 31.
- err is asserted the cycle after the offending request and lasts one cycle per offending cycle.

## Configuration
- **BYPASS_EN defined:** in RUN, for each port i with wen=1 and waddr==raddr_i!=0, the port returns the same-cycle write:
  - rdata_i = wdata
  - rbusy_i = 0, unless rsv_en=1 and rsv_addr==raddr_i in that cycle
- **BYPASS_EN undefined:** reads return registered state only; a same-cycle write is not visible.
- The macro has no effect while ready=0.

## Structure
- **Package register_bank_pkg:**
  - state enum {CLEAR, RUN}
  - localparam defaults for AWIDTH, DWIDTH, NREAD
  - NREAD upper limit (4), checked by an elaboration-time assertion
- **Sub-module register_bank_scoreboard** (parameters AWIDTH, NREAD):
  - holds the busy vector and the reserve/write priority
  - inputs: clk, rst, en (=ready), wen, waddr, rsv_en, rsv_addr, raddr
  - output: rbusy
- The top level holds the storage array, the clear FSM, bypass muxing and err.

## Test plan
- **Reset/clear:** preload location 7 with 0xDEADBEEF, pulse rst 1 cycle, then hold raddr0=7 -> rdata0=0 and ready=0 for cycles 0..30, ready=1 at cycle 31, rdata0=0.
- **Reset mid-clear:** assert rst at cycle 10 of clear -> ready stays 0; ready=1 31 cycles after rst drops.
- **Write/read:** in RUN, wen=1, waddr=5, wdata=0x12345678, raddr0=raddr1=5 -> rdata0=rdata1=0x12345678 next cycle (same cycle with BYPASS_EN); waddr=0 write -> raddr 0 reads 0.
- **Scoreboard:**
  - rsv_en at addr 3 -> rbusy=1 next cycle.
  - wen to 3 -> rbusy=0 next cycle.
  - Simultaneous rsv_en and wen to 3 -> rbusy stays 1 and data updated.
- **Not-ready requests:** wen=1, waddr=9 during CLEAR -> err=1 for one cycle, and location 9 reads 0 after ready.
- **Bypass off:** without BYPASS_EN, wen=1, waddr=raddr0=2, wdata=0xA5 -> rdata0=old value (0) same cycle, 0xA5 next cycle.
